// File: rtl/hop_chain_seq_if.sv
// rtl/hop_chain_seq_if.sv - harness and chain-fabric signals of the hop-chain sequencer
interface hop_chain_seq_if #(
  parameter int LANES = 4,
  parameter int HOPS  = 7,
  parameter int CNT_W = 5
);
  logic                         go;
  logic [LANES-1:0]             lane_mask;
  logic [LANES-1:0]             chain_out;
  logic                         launch_rst;
  logic [LANES*(HOPS-1)-1:0]    stage_rst;
  logic [LANES-1:0]             start;
  logic                         busy;
  logic                         done;
  logic                         pass;
  logic [LANES-1:0]             err_mask;
  logic [LANES*CNT_W-1:0]       lat;

  modport master (
    output go, lane_mask, chain_out,
    input  launch_rst, stage_rst, start, busy, done, pass, err_mask, lat
  );

  modport slave (
    input  go, lane_mask, chain_out,
    output launch_rst, stage_rst, start, busy, done, pass, err_mask, lat
  );
endinterface

// File: rtl/hop_chain_seq.sv
// rtl/hop_chain_seq.sv - reset-release and launch sequencer for hop-chain flop benchmarks
// Every output is a register loaded from its next-state value computed in the single always_comb.
module hop_chain_seq #(
  parameter int LANES    = 4,
  parameter int HOPS     = 7,
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 5,
  parameter int TIMEOUT  = 31
) (
  input  logic            clock0,
  input  logic            rst_n,
  hop_chain_seq_if.slave  bus
);
  localparam int SW = LANES * (HOPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RELEASE, S_CHECK, S_LAUNCH, S_WAIT, S_REPORT
  } state_t;

  state_t                 r_state,      w_state_nxt;
  logic [LANES-1:0]       r_mask,       w_mask_nxt;
  logic [LANES-1:0]       r_arrived,    w_arrived_nxt;
  logic [CNT_W-1:0]       r_cnt,        w_cnt_nxt;
  logic                   r_launch_rst, w_launch_rst_nxt;
  logic [SW-1:0]          r_stage_rst,  w_stage_rst_nxt;
  logic [LANES-1:0]       r_start,      w_start_nxt;
  logic                   r_busy,       w_busy_nxt;
  logic                   r_done,       w_done_nxt;
  logic                   r_pass,       w_pass_nxt;
  logic [LANES-1:0]       r_err,        w_err_nxt;
  logic [LANES*CNT_W-1:0] r_lat,        w_lat_nxt;

  logic [LANES-1:0] w_hit;
  logic [LANES-1:0] w_arr_all;
  logic [LANES-1:0] w_err_fin;
  logic             w_wait_exit;

  // A lane arrives on its first high while enabled; same-cycle arrival beats timeout.
  assign w_hit       = r_mask & ~r_arrived & bus.chain_out;
  assign w_arr_all   = r_arrived | w_hit;
  assign w_err_fin   = r_err | (r_mask & ~w_arr_all);
  assign w_wait_exit = ((w_arr_all & r_mask) == r_mask) || (r_cnt == CNT_W'(TIMEOUT));

  always_comb begin
    w_state_nxt      = r_state;
    w_mask_nxt       = r_mask;
    w_arrived_nxt    = r_arrived;
    w_cnt_nxt        = r_cnt;
    w_launch_rst_nxt = r_launch_rst;
    w_stage_rst_nxt  = r_stage_rst;
    w_start_nxt      = r_start;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_pass_nxt       = r_pass;
    w_err_nxt        = r_err;
    w_lat_nxt        = r_lat;

    case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          w_state_nxt   = S_HOLD;
          w_mask_nxt    = bus.lane_mask;
          w_arrived_nxt = '0;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_pass_nxt    = 1'b0;
          w_err_nxt     = '0;
          w_lat_nxt     = '0;
          w_cnt_nxt     = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
          w_state_nxt      = S_RELEASE;
          w_cnt_nxt        = '0;
          w_launch_rst_nxt = 1'b0;
          for (int l = 0; l < LANES; l++) w_stage_rst_nxt[l*(HOPS-1)] = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        // r_cnt is the release step already applied; the next step clears one stage further.
        if (r_cnt == CNT_W'(HOPS - 2)) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          for (int l = 0; l < LANES; l++)
            for (int k = 1; k < HOPS - 1; k++)
              if (CNT_W'(k) == r_cnt + 1'b1) w_stage_rst_nxt[l*(HOPS-1)+k] = 1'b0;
        end
      end
      S_CHECK: begin
        w_err_nxt   = r_err | (r_mask & bus.chain_out);
        w_start_nxt = r_mask;
        w_cnt_nxt   = '0;
        w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_start_nxt = '0;
        w_cnt_nxt   = CNT_W'(1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_arrived_nxt = w_arr_all;
        for (int l = 0; l < LANES; l++)
          if (w_hit[l]) w_lat_nxt[l*CNT_W +: CNT_W] = r_cnt;
        if (w_wait_exit) begin
          w_state_nxt      = S_REPORT;
          w_err_nxt        = w_err_fin;
          w_pass_nxt       = (w_err_fin == '0);
          w_done_nxt       = 1'b1;
          w_busy_nxt       = 1'b0;
          w_launch_rst_nxt = 1'b1;
          w_stage_rst_nxt  = '1;
        end else if (r_cnt != CNT_W'(TIMEOUT)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock0 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_arrived    <= '0;
      r_cnt        <= '0;
      r_launch_rst <= 1'b1;
      r_stage_rst  <= '1;
      r_start      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_lat        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_arrived    <= w_arrived_nxt;
      r_cnt        <= w_cnt_nxt;
      r_launch_rst <= w_launch_rst_nxt;
      r_stage_rst  <= w_stage_rst_nxt;
      r_start      <= w_start_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_err        <= w_err_nxt;
      r_lat        <= w_lat_nxt;
    end
  end

  assign bus.launch_rst = r_launch_rst;
  assign bus.stage_rst  = r_stage_rst;
  assign bus.start      = r_start;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pass       = r_pass;
  assign bus.err_mask   = r_err;
  assign bus.lat        = r_lat;
endmodule

// File: tb/tb_hop_chain_seq.sv
// tb/tb_hop_chain_seq.sv - scoreboard bench for hop_chain_seq with a hop-chain fabric model
// Expected results are queued at go; a done-edge monitor pops and compares them.
module tb_hop_chain_seq;
  localparam int LANES = 4;
  localparam int HOPS  = 7;
  localparam int CNT_W = 5;

  typedef struct {
    logic [3:0]  err;
    logic        pass;
    logic [19:0] lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] stuck0, stuck1;
  logic [HOPS-1:0] q [LANES];
  logic prev_done;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  hop_chain_seq_if #(.LANES(LANES), .HOPS(HOPS), .CNT_W(CNT_W)) bus ();

  hop_chain_seq #(.LANES(LANES), .HOPS(HOPS), .HOLD_CYC(4), .CNT_W(CNT_W), .TIMEOUT(31))
    dut (.clock0(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Ideal chain fabric: launch flop then HOPS-1 stages, each with its own sync reset.
  always @(posedge clk or negedge rst_n) begin
    for (int l = 0; l < LANES; l++) begin
      if (!rst_n) q[l] <= '0;
      else begin
        q[l][0] <= bus.launch_rst ? 1'b0 : bus.start[l];
        for (int k = 0; k < HOPS - 1; k++)
          q[l][k+1] <= bus.stage_rst[l*(HOPS-1)+k] ? 1'b0 : q[l][k];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++)
      bus.chain_out[l] = stuck1[l] | (~stuck0[l] & q[l][HOPS-1]);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [19:0] lats(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done && !prev_done) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("err_mask", 64'(bus.err_mask), 64'(e.err));
        chk("pass", 64'(bus.pass), 64'(e.pass));
        for (int l = 0; l < LANES; l++)
          chk($sformatf("lat%0d", l), 64'(bus.lat[l*CNT_W +: CNT_W]), 64'(e.lat[l*CNT_W +: CNT_W]));
      end
    end
    prev_done <= bus.done;
  end

  task automatic run(input logic [3:0] mask, input logic [3:0] e_err, input logic e_pass,
                     input logic [19:0] e_lat, input int e_done_n, input bit midgo);
    int n, first, hi;
    logic [3:0] seen;
    exp_t e;
    e.err = e_err; e.pass = e_pass; e.lat = e_lat;
    sb.push_back(e);
    @(negedge clk);
    bus.go = 1'b1;
    bus.lane_mask = mask;
    @(negedge clk);
    bus.go = 1'b0;
    n = 1; first = 0; hi = 0; seen = '0;
    while (!bus.done && n < 200) begin
      if (bus.start != 0) begin
        hi++;
        if (first == 0) first = n;
        seen |= bus.start;
      end
      if (midgo && n == 5) begin bus.go = 1'b1; bus.lane_mask = ~mask; end
      if (midgo && n == 6) bus.go = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("done_cycle", 64'(n), 64'(e_done_n));
    chk("start_value", 64'(seen), 64'(mask));
    if (mask != 0) begin
      chk("start_cycle", 64'(first), 64'd12);
      chk("start_width", 64'(hi), 64'd1);
    end else begin
      chk("start_width", 64'(hi), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.go = 1'b0;
    bus.lane_mask = '0;
    stuck0 = '0;
    stuck1 = '0;
    prev_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_launch_rst", 64'(bus.launch_rst), 64'd1);
    chk("rst_stage_rst", 64'(bus.stage_rst), 64'hFFFFFF);
    chk("rst_outputs", 64'({bus.start, bus.busy, bus.done, bus.pass, bus.err_mask}), 64'd0);
    chk("rst_lat", 64'(bus.lat), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4'b1111, 4'b0000, 1'b1, lats(7, 7, 7, 7), 20, 1'b0);

    stuck0 = 4'b0100;
    run(4'b1111, 4'b0100, 1'b0, lats(7, 7, 0, 7), 44, 1'b0);
    stuck0 = '0;

    stuck1 = 4'b0010;
    run(4'b1111, 4'b0010, 1'b0, lats(7, 1, 7, 7), 20, 1'b0);
    stuck1 = '0;

    run(4'b0101, 4'b0000, 1'b1, lats(7, 0, 7, 0), 20, 1'b0);
    run(4'b0000, 4'b0000, 1'b1, lats(0, 0, 0, 0), 14, 1'b0);

    // Abort in WAIT: async reset forces all resets back on at once.
    @(negedge clk);
    bus.go = 1'b1;
    bus.lane_mask = 4'b1111;
    @(negedge clk);
    bus.go = 1'b0;
    n = 1;
    while (n < 15) begin @(negedge clk); n++; end
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_stage_rst", 64'(bus.stage_rst), 64'hFFFFFF);
    chk("abort_launch_rst", 64'(bus.launch_rst), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(4'b1111, 4'b0000, 1'b1, lats(7, 7, 7, 7), 20, 1'b0);

    run(4'b0101, 4'b0000, 1'b1, lats(7, 0, 7, 0), 20, 1'b1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
